mem_store_narrow16: RTL
=======================

Name: mem_store_narrow16

Overview:
- Store-side narrowing unit for the MIPS datapath; it performs the reverse of load-side sign extension.
- Accepts one 32-bit store request (SB/SH/SW) from the MEM stage.
- Drives a 16-bit data memory port: byte/halfword stores take 1 beat, word stores take 2 halfword beats.
- Stalls the pipeline through req_ready until the store completes.

Parameters:
ADDR_W, 32, width of the byte address on request and memory sides

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  store request present
req_ready  output  1  unit idle and able to accept a request
req_addr  input  ADDR_W  byte address of the store
req_wdata  input  32  store data from rt register
req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved
mem_valid  output  1  memory beat valid
mem_ready  input  1  memory accepts the beat
mem_addr  output  ADDR_W  halfword-aligned beat address (bit 0 always 0)
mem_wdata  output  16  beat data
mem_be  output  2  byte enables; bit0 = low byte (even address), bit1 = high byte
done  output  1  one-cycle pulse: store completed
err  output  1  one-cycle pulse: misaligned or reserved-size request, dropped

Behaviour:
- Reset values (next edge with reset=1):
  - state = IDLE, req_ready = 1
  - mem_valid = 0, mem_addr = 0, mem_wdata = 0, mem_be = 00
  - done = 0, err = 0
- Reset mid-transfer aborts immediately; no further beats are issued.
- Outputs: all are registered except req_ready, which is state == IDLE.
- States: IDLE, BEAT0, BEAT1.
- Accept: occurs when req_valid and req_ready are both high at an edge. Request fields are captured; req_* is ignored in every other state.
- Error check at accept:
  - Error if req_size = 11, or half with addr[0] = 1, or word with addr[1:0] != 00.
  - On error: err = 1 for the next cycle, state stays IDLE, no bus activity.
- Byte store, one beat:
  - mem_addr = {addr[ADDR_W-1:1], 0}
  - mem_wdata = {wdata[7:0], wdata[7:0]}
  - mem_be = 10 if addr[0] = 1, else 01
- Half store, one beat: mem_addr = addr, mem_wdata = wdata[15:0], mem_be = 11.
- Word store, little-endian, two beats:
  - BEAT0: mem_addr = addr, mem_wdata = wdata[15:0], mem_be = 11.
  - BEAT1: mem_addr = addr + 2 (wraps modulo 2^ADDR_W), mem_wdata = wdata[31:16], mem_be = 11.
- Transitions:
  - IDLE -> BEAT0 on a valid accept.
  - BEAT0 -> BEAT1 on handshake for word stores.
  - BEAT0 -> IDLE on handshake for byte/half stores.
  - BEAT1 -> IDLE on handshake.
- Latency:
  - Accept at edge T -> mem_valid = 1 during cycle T+1.
  - Handshake = mem_valid and mem_ready at an edge.
  - With mem_ready held high: byte/half done during T+2; word done during T+3 (beats in T+1 and T+2).
- Hold rule: while mem_valid = 1 and mem_ready = 0, mem_addr, mem_wdata and mem_be hold stable.
- Beat spacing:
  - mem_valid drops in the cycle after the final handshake.
  - No idle cycle is inserted between BEAT0 and BEAT1.
- Completion:
  - done pulses in the cycle after the final handshake; req_ready = 1 in that same cycle.
  - A new request may be accepted at the edge ending the done cycle.
- done and err are never high together. Neither is asserted while reset is high.

Test Plan:
1. Word store: addr = 0x1000, wdata = 0xDEADBEEF, mem_ready = 1 -> beat 0x1000/0xBEEF/11, then beat 0x1002/0xDEAD/11, done during T+3, req_ready low during T+1..T+2.
2. Byte store: addr = 0x2003, wdata = 0x000000A5 -> single beat 0x2002/0xA5A5/be = 10, done during T+2. Repeat with addr = 0x2002 -> be = 01.
3. Backpressure: half store addr = 0x0040, wdata = 0x00001234, mem_ready low for 3 cycles -> mem_addr/mem_wdata/mem_be held at 0x0040/0x1234/11 through the stall; exactly one handshake; done one cycle after it.
4. Misaligned and reserved requests: word at 0x0006, half at 0x0011, size = 11 at 0x0000 -> err pulse each, mem_valid never asserted, req_ready stays 1.
5. Reset mid-word: assert reset during BEAT1 (stall with mem_ready = 0) -> next edge mem_valid = 0, req_ready = 1, no done pulse; a following store executes normally.
6. Back-to-back and wrap: two word stores with req_valid held high, second at addr 0xFFFFFFFC -> second request accepted at the edge ending the first done cycle; second store's BEAT1 mem_addr = 0xFFFFFFFE; third store at addr 0xFFFFFFFE (half) issues a single beat to 0xFFFFFFFE.

Source files
------------

// File: rtl/mem_store_narrow16.sv
// Store-side narrowing unit: splits SB/SH/SW store requests into beats on a
// 16-bit data memory port, stalling the pipeline via req_ready until done.
module mem_store_narrow16 #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_be,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t            state, state_d;
    logic              is_word, is_word_d;
    logic [15:0]       hi_data, hi_data_d;
    logic              mem_valid_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [15:0]       mem_wdata_d;
    logic [1:0]        mem_be_d;
    logic              done_d, err_d;
    logic              bad_req;
    logic              handshake;

    assign req_ready = (state == IDLE);
    assign handshake = mem_valid && mem_ready;

    assign bad_req = (req_size == 2'b11)
                  || (req_size == SZ_HALF && req_addr[0])
                  || (req_size == SZ_WORD && (req_addr[1:0] != 2'b00));

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state;
        is_word_d   = is_word;
        hi_data_d   = hi_data;
        mem_valid_d = mem_valid;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_be_d    = mem_be;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (bad_req) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = BEAT0;
                        mem_valid_d = 1'b1;
                        is_word_d   = (req_size == SZ_WORD);
                        hi_data_d   = req_wdata[31:16];
                        if (req_size == SZ_BYTE) begin
                            mem_addr_d  = {req_addr[ADDR_W-1:1], 1'b0};
                            mem_wdata_d = {req_wdata[7:0], req_wdata[7:0]};
                            mem_be_d    = req_addr[0] ? 2'b10 : 2'b01;
                        end else begin
                            mem_addr_d  = req_addr;
                            mem_wdata_d = req_wdata[15:0];
                            mem_be_d    = 2'b11;
                        end
                    end
                end
            end
            BEAT0: begin
                if (handshake) begin
                    if (is_word) begin
                        // Upper halfword follows immediately; valid stays high.
                        state_d     = BEAT1;
                        mem_addr_d  = mem_addr + ADDR_W'(2);
                        mem_wdata_d = hi_data;
                        mem_be_d    = 2'b11;
                    end else begin
                        state_d     = IDLE;
                        mem_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (handshake) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            is_word   <= 1'b0;
            hi_data   <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 2'b00;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            is_word   <= is_word_d;
            hi_data   <= hi_data_d;
            mem_valid <= mem_valid_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_be    <= mem_be_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule
